// File: rtl/opennic_pkg.sv
// Shared constants, enums and header field accessors for the opennic_shell packet processor.
package opennic_pkg;
  localparam int unsigned OFF_ETYPE  = 12;
  localparam int unsigned OFF_INNER  = 16;
  localparam int unsigned OFF_PROTO  = 27;
  localparam int unsigned OFF_DPORT  = 40;
  localparam int unsigned OFF_KEY    = 46;
  localparam int unsigned OFF_IDX    = 48;
  localparam int unsigned OFF_OP     = 49;
  localparam int unsigned OFF_A      = 48;
  localparam int unsigned OFF_B      = 52;
  localparam int unsigned OFF_RES    = 56;
  localparam int unsigned RES_END    = 60;

  localparam logic [15:0] ETH_VLAN = 16'h8100;
  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_UDP   = 8'h11;

  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2} op_e;
  typedef enum logic {ST_FIRST, ST_BODY} parse_e;
  typedef enum logic [1:0] {CLS_PASS, CLS_CTRL, CLS_DATA} cls_e;

  // Header fields are big-endian; byte k sits at bits [8k+7:8k].
  function automatic logic [7:0] get8(logic [511:0] d, int unsigned off);
    return d[8*off +: 8];
  endfunction

  function automatic logic [15:0] get16(logic [511:0] d, int unsigned off);
    return {d[8*off +: 8], d[8*(off+1) +: 8]};
  endfunction

  function automatic logic [31:0] get32(logic [511:0] d, int unsigned off);
    return {get16(d, off), get16(d, off + 2)};
  endfunction
endpackage

// File: rtl/opennic_shell_if.sv
// AXI-Stream bundle with QDMA/CMAC sideband fields; the DUT drives master and consumes slave.
interface opennic_shell_if #(parameter int unsigned DATA_W = 512);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [5:0]          tuser_mty;
  logic                tuser_err;
  logic                tuser_zero_byte;
  logic [31:0]         tuser_mdata;
  logic [10:0]         tuser_qid;
  logic [2:0]          tuser_port_id;
  logic [31:0]         tcrc;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser_mty, tuser_err, tuser_zero_byte,
           tuser_mdata, tuser_qid, tuser_port_id, tcrc,
    input  tready
  );
  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser_mty, tuser_err, tuser_zero_byte,
           tuser_mdata, tuser_qid, tuser_port_id, tcrc,
    output tready
  );
endinterface

// File: rtl/opennic_op_table.sv
// Register CAM mapping 16-bit keys to ALU ops; lowest matching valid index wins.
module opennic_op_table
  import opennic_pkg::*;
#(
  parameter int unsigned TBL_DEPTH = 8,
  parameter int unsigned IDX_W     = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_key,
  input  logic [1:0]       wr_op,
  input  logic [15:0]      lk_key,
  output logic             hit,
  output op_e              op
);
  logic [15:0]          key_q [TBL_DEPTH];
  logic [1:0]           op_q  [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        key_q[i] <= '0;
        op_q[i]  <= '0;
      end
    end else if (wr_en) begin
      vld_q[wr_idx] <= 1'b1;
      key_q[wr_idx] <= wr_key;
      op_q[wr_idx]  <= wr_op;
    end
  end

  always_comb begin
    hit = 1'b0;
    op  = OP_NOP;
    for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
      if (!hit && vld_q[i] && key_q[i] == lk_key) begin
        hit = 1'b1;
        op  = op_e'(op_q[i]);
      end
    end
  end
endmodule

// File: rtl/opennic_shell.sv
// H2C-to-CMAC stream processor: absorbs table-programming packets, applies keyed ALU ops to data packets.
module opennic_shell
  import opennic_pkg::*;
#(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned TBL_DEPTH = 8,
  parameter logic [15:0] CTRL_PORT = 16'hF1F2
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   axis_aclk,
  opennic_shell_if.slave         s_axis_qdma_h2c_sim,
  opennic_shell_if.master        m_axis_cmac_tx_sim
);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;

  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_fire, s_ready;
  parse_e            state, state_n;
  cls_e              cls_q, cls_n, cls_first, cls_cur;
  logic              hdr_ok, short_first, do_mod, drop, wr_en, hit;
  op_e               op;
  logic [31:0]       a, b, res;
  logic [DATA_W-1:0] mod_data;
  logic [KEEP_W-1:0] keep_in;
  logic [IDX_W-1:0]  wr_idx;

  logic              s1_valid, s1_last, s2_valid, s2_last, s2_load, s1_adv;
  logic [DATA_W-1:0] s1_data, s2_data;
  logic [KEEP_W-1:0] s1_keep, s2_keep;

  assign rst     = aresetn;
  assign in_data = s_axis_qdma_h2c_sim.tdata;
  assign in_fire = s_axis_qdma_h2c_sim.tvalid && s_ready;

  assign hdr_ok    = get16(in_data, OFF_ETYPE) == ETH_VLAN && get16(in_data, OFF_INNER) == ETH_IPV4
                     && get8(in_data, OFF_PROTO) == IP_UDP;
  assign cls_first = !hdr_ok ? CLS_PASS :
                     (get16(in_data, OFF_DPORT) == CTRL_PORT) ? CLS_CTRL : CLS_DATA;
  assign cls_cur   = (state == ST_FIRST) ? cls_first : cls_q;
  assign drop      = (cls_cur == CLS_CTRL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FIRST;
      cls_q <= CLS_PASS;
    end else begin
      state <= state_n;
      cls_q <= cls_n;
    end
  end

  always_comb begin
    state_n = state;
    cls_n   = cls_q;
    if (in_fire) begin
      unique case (state)
        ST_FIRST: begin
          cls_n = cls_first;
          if (!s_axis_qdma_h2c_sim.tlast) state_n = ST_BODY;
        end
        ST_BODY: if (s_axis_qdma_h2c_sim.tlast) state_n = ST_FIRST;
      endcase
    end
  end

  assign wr_en  = in_fire && state == ST_FIRST && cls_first == CLS_CTRL;
  assign wr_idx = IDX_W'((32'(get8(in_data, OFF_IDX) & 8'h07)) % TBL_DEPTH);

  opennic_op_table #(.TBL_DEPTH(TBL_DEPTH), .IDX_W(IDX_W)) u_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_key (get16(in_data, OFF_KEY)),
    .wr_op  (get8(in_data, OFF_OP) & 8'h03),
    .lk_key (get16(in_data, OFF_KEY)),
    .hit    (hit),
    .op     (op)
  );

  // A single-beat frame too short to hold the result field is forwarded untouched.
  assign short_first = s_axis_qdma_h2c_sim.tlast
                       && (KEEP_W - 32'(s_axis_qdma_h2c_sim.tuser_mty)) < RES_END;
  assign a      = get32(in_data, OFF_A);
  assign b      = get32(in_data, OFF_B);
  assign res    = (op == OP_SUB) ? a - b : a + b;
  assign do_mod = state == ST_FIRST && cls_first == CLS_DATA && hit && !short_first
                  && (op == OP_ADD || op == OP_SUB);

  always_comb begin
    mod_data = in_data;
    if (do_mod) begin
      for (int unsigned i = 0; i < 4; i++) mod_data[8*(OFF_RES+i) +: 8] = res[8*(3-i) +: 8];
    end
  end

  assign keep_in = s_axis_qdma_h2c_sim.tlast ? ({KEEP_W{1'b1}} >> s_axis_qdma_h2c_sim.tuser_mty)
                                             : {KEEP_W{1'b1}};

  assign s2_load = !s2_valid || m_axis_cmac_tx_sim.tready;
  assign s1_adv  = s1_valid && s2_load;
  assign s_ready = !s1_valid || s1_adv;

  // Control beats are accepted but never enter stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_keep  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
      s2_keep  <= '0;
    end else begin
      if (s_ready) begin
        s1_valid <= in_fire && !drop;
        if (in_fire) begin
          s1_data <= mod_data;
          s1_keep <= keep_in;
          s1_last <= s_axis_qdma_h2c_sim.tlast;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_keep <= s1_keep;
          s2_last <= s1_last;
        end
      end
    end
  end

  assign s_axis_qdma_h2c_sim.tready       = s_ready;
  assign m_axis_cmac_tx_sim.tdata         = s2_data;
  assign m_axis_cmac_tx_sim.tkeep         = s2_keep;
  assign m_axis_cmac_tx_sim.tvalid        = s2_valid;
  assign m_axis_cmac_tx_sim.tlast         = s2_last;
  assign m_axis_cmac_tx_sim.tuser_err     = 1'b0;
  assign m_axis_cmac_tx_sim.tuser_mty     = '0;
  assign m_axis_cmac_tx_sim.tuser_zero_byte = 1'b0;
  assign m_axis_cmac_tx_sim.tuser_mdata   = '0;
  assign m_axis_cmac_tx_sim.tuser_qid     = '0;
  assign m_axis_cmac_tx_sim.tuser_port_id = '0;
  assign m_axis_cmac_tx_sim.tcrc          = '0;
endmodule

// File: tb/tb_opennic_shell.sv
// Scoreboard bench for opennic_shell: expected beats queued at drive time, compared at output handshake.
module tb_opennic_shell;
  localparam logic [15:0] CTRL_PORT = 16'hF1F2;
  localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_ready = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  beat_t sb[$];

  opennic_shell_if #(.DATA_W(512)) s_if ();
  opennic_shell_if #(.DATA_W(512)) m_if ();

  opennic_shell #(.DATA_W(512), .TBL_DEPTH(8), .CTRL_PORT(CTRL_PORT)) dut (
    .clk                 (clk),
    .aresetn             (rst),
    .axis_aclk           (clk),
    .s_axis_qdma_h2c_sim (s_if),
    .m_axis_cmac_tx_sim  (m_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [511:0] put8(logic [511:0] d, int unsigned off, logic [7:0] v);
    d[8*off +: 8] = v;
    return d;
  endfunction

  function automatic logic [511:0] put16(logic [511:0] d, int unsigned off, logic [15:0] v);
    return put8(put8(d, off, v[15:8]), off + 1, v[7:0]);
  endfunction

  function automatic logic [511:0] put32(logic [511:0] d, int unsigned off, logic [31:0] v);
    return put16(put16(d, off, v[31:16]), off + 2, v[15:0]);
  endfunction

  function automatic logic [511:0] frame(logic [15:0] etype, logic [15:0] dport, logic [15:0] key,
                                         logic [31:0] a, logic [31:0] b, logic [31:0] f);
    logic [511:0] d;
    d = rnd512();
    d = put16(d, 12, etype);
    d = put16(d, 16, 16'h0800);
    d = put8(d, 27, 8'h11);
    d = put16(d, 40, dport);
    d = put16(d, 46, key);
    d = put32(d, 48, a);
    d = put32(d, 52, b);
    d = put32(d, 56, f);
    return d;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic last, input logic [5:0] mty);
    int unsigned n = 0;
    bit ok = 1'b0;
    s_if.tdata = d;
    s_if.tlast = last;
    s_if.tuser_mty = mty;
    s_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = s_if.tready;
      n++;
      @(posedge clk);
      #1;
    end while (!ok && n < 500);
    if (!ok) check("in_timeout", s_if.tready, 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic expect_beat(input logic [511:0] d, input logic [63:0] keep, input logic last);
    beat_t e;
    e.data = d;
    e.keep = keep;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic ctrl_pkt(input logic [7:0] idx, input logic [15:0] key, input logic [7:0] op);
    logic [511:0] d;
    d = frame(16'h8100, CTRL_PORT, key, 32'h0, 32'h0, 32'h0);
    d = put8(put8(d, 48, idx), 49, op);
    send_beat(d, 1'b1, 6'd0);
  endtask

  task automatic data_pkt(input logic [15:0] etype, input logic [15:0] key, input logic [31:0] a,
                          input logic [31:0] b, input bit modify, input logic [31:0] r,
                          input logic [5:0] mty);
    logic [511:0] d;
    d = frame(etype, 16'h1111, key, a, b, 32'h0);
    expect_beat(modify ? put32(d, 56, r) : d, ONES >> mty, 1'b1);
    send_beat(d, 1'b1, mty);
  endtask

  always begin
    @(posedge clk);
    #1;
    m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit           hold_pending = 1'b0;
  logic [511:0] hold_data;
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst) begin
      if (hold_pending) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", m_if.tdata, hold_data);
      end
      hold_pending = m_if.tvalid && !m_if.tready;
      hold_data    = m_if.tdata;
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          check("spurious_beat", m_if.tvalid, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", m_if.tdata, e.data);
          check("out_keep", m_if.tkeep, e.keep);
          check("out_last", m_if.tlast, e.last);
          check("out_err", m_if.tuser_err, 0);
        end
      end
    end
  end

  initial begin
    logic [511:0] d;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
    s_if.tuser_mty = '0; s_if.tuser_err = 1'b0; s_if.tuser_zero_byte = 1'b0;
    s_if.tuser_mdata = '0; s_if.tuser_qid = '0; s_if.tuser_port_id = '0; s_if.tcrc = '0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tready", s_if.tready, 1);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_tkeep", m_if.tkeep, 0);
    check("rst_tlast", m_if.tlast, 0);
    @(posedge clk); #1;

    // Empty table: key later programmed as SUB must pass unchanged.
    data_pkt(16'h8100, 16'h001A, 32'd3, 32'd2, 1'b0, 32'h0, 6'd0);
    ctrl_pkt(8'd0, 16'h001A, 8'd2);
    ctrl_pkt(8'd1, 16'h000D, 8'd1);
    d = put8(put8(frame(16'h8100, CTRL_PORT, 16'h0055, 32'h0, 32'h0, 32'h0), 48, 8'd3), 49, 8'd3);
    send_beat(d, 1'b0, 6'd0);
    send_beat(rnd512(), 1'b1, 6'd10);

    data_pkt(16'h8100, 16'h001A, 32'd3, 32'd2, 1'b1, 32'h0000_0001, 6'd0);
    data_pkt(16'h8100, 16'h000D, 32'd3, 32'd2, 1'b1, 32'h0000_0005, 6'd0);
    data_pkt(16'h8100, 16'h1234, 32'd3, 32'd2, 1'b0, 32'h0, 6'd0);
    data_pkt(16'h8100, 16'h001A, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 6'd0);
    data_pkt(16'h8100, 16'h000D, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0000_0000, 6'd0);
    data_pkt(16'h8100, 16'h000D, 32'd3, 32'd2, 1'b0, 32'h0, 6'd5);
    data_pkt(16'h8100, 16'h000D, 32'd3, 32'd2, 1'b1, 32'h0000_0005, 6'd4);
    data_pkt(16'h8100, 16'h0055, 32'd3, 32'd2, 1'b0, 32'h0, 6'd0);
    data_pkt(16'h0800, 16'h000D, 32'd3, 32'd2, 1'b0, 32'h0, 6'd0);

    // Write immediately followed by lookup; then a higher-index duplicate key must lose.
    ctrl_pkt(8'd2, 16'h0077, 8'd1);
    data_pkt(16'h8100, 16'h0077, 32'd10, 32'd20, 1'b1, 32'd30, 6'd0);
    ctrl_pkt(8'd12, 16'h001A, 8'd1);
    data_pkt(16'h8100, 16'h001A, 32'd7, 32'd2, 1'b1, 32'd5, 6'd0);

    d = frame(16'h8100, 16'h2222, 16'h000D, 32'd100, 32'd23, 32'h0);
    expect_beat(put32(d, 56, 32'd123), ONES, 1'b0);
    send_beat(d, 1'b0, 6'd0);
    d = put16(rnd512(), 46, 16'h000D);
    expect_beat(d, ONES, 1'b1);
    send_beat(d, 1'b1, 6'd0);

    rand_ready = 1'b1;
    d = frame(16'h0800, 16'h1111, 16'h000D, 32'd1, 32'd1, 32'h0);
    expect_beat(d, ONES, 1'b0);
    send_beat(d, 1'b0, 6'd0);
    d = rnd512();
    expect_beat(d, ONES, 1'b0);
    send_beat(d, 1'b0, 6'd0);
    d = rnd512();
    expect_beat(d, 64'h0000_0000_0000_7FFF, 1'b1);
    send_beat(d, 1'b1, 6'd49);
    data_pkt(16'h8100, 16'h001A, 32'd9, 32'd4, 1'b1, 32'd5, 6'd0);
    data_pkt(16'h8100, 16'h000D, 32'd9, 32'd4, 1'b1, 32'd13, 6'd0);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
    check("idle_tvalid", m_if.tvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
